fp_stream_accumulator: RTL and testbench
========================================

Name: fp_stream_accumulator

Overview:
Sequential stage wrapped around the combinational IEEE-754 single-precision adder, adder_floating_point. It accepts a stream of float operands over a valid/ready handshake and adds or subtracts each operand into a running sum. It returns the final sum, beat count and sticky exception flags when the last beat of a packet arrives. It sits between the operand source and the result consumer, and is the registered consumer of the adder's op/over/under outputs.

Parameters:
CNT_W, 8, width of beat counter; the counter saturates at 2^CNT_W-1.
INIT_SUM, 32'h0000_0000, accumulator value after reset and after each result handoff (+0.0).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  stage can accept an operand.
in_data  in  32  IEEE-754 single operand.
in_sub  in  1  1 = subtract in_data from the sum; 0 = add. Drives the adder's sub input.
in_last  in  1  final beat of the packet.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_sum  out  32  accumulated IEEE-754 sum.
out_count  out  CNT_W  number of beats accumulated, saturating.
out_over  out  1  sticky: adder overflow seen during the packet.
out_under  out  1  sticky: adder underflow seen during the packet.
out_nan  out  1  sticky NaN input seen. Active only with the optional feature; otherwise tied to 0.

Behaviour:
- Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - state = ACC
  - acc = INIT_SUM; count = 0
  - all sticky flags = 0
  - out_valid = 0; in_ready = 1
  - out_sum = INIT_SUM; out_count = 0
- One adder instance, purely combinational: a = acc, b = in_data, sub = in_sub.
- State ACC:
  - in_ready = 1, out_valid = 0.
  - Beat accepted when in_valid & in_ready. On the same edge:
    - acc <= adder op
    - count <= count+1, saturating at all-ones
    - over_s |= over; under_s |= under
  - If the accepted beat has in_last = 1, go to HOLD.
  - If in_valid = 0, nothing changes.
- State HOLD:
  - in_ready = 0, out_valid = 1.
  - out_sum, out_count and the sticky flags are held stable while out_ready = 0.
  - On out_valid & out_ready, all of the following happen on the same edge:
    - acc <= INIT_SUM, count <= 0, sticky flags <= 0
    - go to ACC
  - in_ready rises the cycle after the handoff. There is no same-cycle pass-through.
- Latency: out_valid asserts on the first rising edge after the last beat is accepted. The minimum packet period is (beats + 1) cycles.
- A single-beat packet (in_last on the first beat) gives out_sum = INIT_SUM ± in_data and out_count = 1.
- Outputs out_sum, out_count and the flags are registered copies of acc, count and the stickies, and are valid only while out_valid = 1.
- Rounding, denormals and specials follow adder_floating_point exactly. This stage adds no rounding.
- Reset mid-packet or while in HOLD discards the partial sum and the pending result, and returns to the reset values on that edge.
- in_data, in_sub and in_last are ignored when no beat is accepted.

Optional Feature:
Macro FP_ACC_NAN_STICKY_EN.
- Defined:
  - Any accepted beat with in_data[30:23] = 8'hFF and in_data[22:0] != 0 sets sticky nan_s, presented on out_nan in HOLD.
  - nan_s clears on handoff and on reset.
  - acc is still updated from the adder.
- Undefined: out_nan is constant 0 and no NaN detection logic is built.

Test Plan:
1. Add packet: 3F800000, 40000000, 3F000000 (last), all in_sub = 0 → out_valid one cycle after the last beat; out_sum = 40600000 (3.5); out_count = 3; over = under = 0.
2. Subtract: 40400000 (in_sub = 0), 3F800000 (in_sub = 1, last) → out_sum = 40000000 (2.0); out_count = 2.
3. Overflow: 7F7FFFFF then 7F7FFFFF (last), both in_sub = 0 → out_over = 1 and out_sum matches the adder's reference result. The next packet, 3F800000 (last), gives out_over = 0 and out_sum = 3F800000.
4. Backpressure: after a packet ends, hold out_ready = 0 for 5 cycles while in_valid = 1 → in_ready = 0 and out_sum/out_count stable throughout. Raise out_ready → handoff; in_ready = 1 on the next cycle.
5. Reset mid-packet: accept 40000000, then assert rst for 1 cycle, then send 3F800000 (last) → out_sum = 3F800000, out_count = 1.
6. With CNT_W = 2: send 5 beats of 3F800000 → out_count = 3 (saturated); out_sum = 40A00000 (5.0). With FP_ACC_NAN_STICKY_EN defined, a 7FC00000 beat → out_nan = 1.

Source files
------------

// File: rtl/adder_floating_point.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even.
// Subnormals are flushed to zero on input and output; NaN results are the canonical 7FC00000.
module adder_floating_point (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] op_o,
  output logic        over_o,
  output logic        under_o
);

  logic              b_sign, a_nan, b_nan, a_inf, b_inf, swap, eff_sub, s_big, sticky, rnd_up;
  logic [7:0]        e_big, e_sml, e_diff;
  logic [23:0]       m_a, m_b, m_big, m_sml;
  logic [26:0]       m_aln, m_nrm;
  logic [27:0]       m_sum;
  logic [24:0]       m_rnd;
  logic [4:0]        lz;
  logic signed [9:0] e_nrm, e_fin;

  assign b_sign  = b_i[31] ^ sub_i;
  assign a_nan   = (&a_i[30:23]) & (|a_i[22:0]);
  assign b_nan   = (&b_i[30:23]) & (|b_i[22:0]);
  assign a_inf   = (&a_i[30:23]) & ~(|a_i[22:0]);
  assign b_inf   = (&b_i[30:23]) & ~(|b_i[22:0]);
  // A zero exponent drops the hidden bit and fraction, so subnormals act as zero.
  assign m_a     = (|a_i[30:23]) ? {1'b1, a_i[22:0]} : 24'd0;
  assign m_b     = (|b_i[30:23]) ? {1'b1, b_i[22:0]} : 24'd0;
  assign swap    = b_i[30:0] > a_i[30:0];
  assign e_big   = swap ? b_i[30:23] : a_i[30:23];
  assign e_sml   = swap ? a_i[30:23] : b_i[30:23];
  assign m_big   = swap ? m_b : m_a;
  assign m_sml   = swap ? m_a : m_b;
  assign s_big   = swap ? b_sign : a_i[31];
  assign eff_sub = a_i[31] ^ b_sign;
  assign e_diff  = e_big - e_sml;

  always_comb begin
    m_aln    = {m_sml, 3'b000} >> e_diff;
    sticky   = |({m_sml, 3'b000} & ~(27'h7FF_FFFF << e_diff));
    m_aln[0] = m_aln[0] | sticky;
    m_sum    = eff_sub ? {1'b0, m_big, 3'b000} - {1'b0, m_aln}
                       : {1'b0, m_big, 3'b000} + {1'b0, m_aln};
    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (m_sum[i]) lz = 5'(26 - i);
    end
    if (m_sum[27]) begin
      m_nrm = {m_sum[27:2], |m_sum[1:0]};
      e_nrm = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      m_nrm = m_sum[26:0] << lz;
      e_nrm = $signed({2'b00, e_big}) - $signed({5'd0, lz});
    end
    rnd_up = m_nrm[2] & (m_nrm[3] | m_nrm[1] | m_nrm[0]);
    m_rnd  = {1'b0, m_nrm[26:3]} + {24'd0, rnd_up};
    e_fin  = e_nrm + $signed({9'd0, m_rnd[24]});

    over_o  = 1'b0;
    under_o = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      op_o = 32'h7FC0_0000;
    end else if (a_inf) begin
      op_o = a_i;
    end else if (b_inf) begin
      op_o = {b_sign, b_i[30:0]};
    end else if (m_sum == '0) begin
      op_o = '0;
    end else if (e_fin >= 10'sd255) begin
      over_o = 1'b1;
      op_o   = {s_big, 8'hFF, 23'd0};
    end else if (e_fin <= 10'sd0) begin
      under_o = 1'b1;
      op_o    = {s_big, 31'd0};
    end else begin
      op_o = {s_big, e_fin[7:0], m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0]};
    end
  end

endmodule

// File: rtl/fp_stream_accumulator.sv
// Streaming float accumulator: sums a packet of operands and presents sum, beat count and
// sticky flags. Define FP_ACC_NAN_STICKY_EN to build the sticky NaN-input flag on out_nan_o.
module fp_stream_accumulator #(
  parameter int unsigned CNT_W    = 8,
  parameter logic [31:0] INIT_SUM = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  input  logic             in_sub_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_sum_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_over_o,
  output logic             out_under_o,
  output logic             out_nan_o
);

  typedef enum logic {StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             over_q, over_d, under_q, under_d;
  logic [31:0]      add_op;
  logic             add_over, add_under;

  adder_floating_point u_adder (
    .a_i     (acc_q),
    .b_i     (in_data_i),
    .sub_i   (in_sub_i),
    .op_o    (add_op),
    .over_o  (add_over),
    .under_o (add_under)
  );

  assign in_ready_o  = (state_q == StAcc);
  assign out_valid_o = (state_q == StHold);
  assign out_sum_o   = acc_q;
  assign out_count_o = cnt_q;
  assign out_over_o  = over_q;
  assign out_under_o = under_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    under_d = under_q;
    unique case (state_q)
      StAcc: begin
        if (in_valid_i) begin
          acc_d   = add_op;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          over_d  = over_q | add_over;
          under_d = under_q | add_under;
          if (in_last_i) state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          acc_d   = INIT_SUM;
          cnt_d   = '0;
          over_d  = 1'b0;
          under_d = 1'b0;
          state_d = StAcc;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StAcc;
      acc_q   <= INIT_SUM;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

`ifdef FP_ACC_NAN_STICKY_EN
  logic nan_q;
  logic in_nan;

  assign in_nan = (&in_data_i[30:23]) & (|in_data_i[22:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nan_q <= 1'b0;
    end else if (state_q == StAcc && in_valid_i && in_nan) begin
      nan_q <= 1'b1;
    end else if (state_q == StHold && out_ready_i) begin
      nan_q <= 1'b0;
    end
  end

  assign out_nan_o = nan_q;
`else
  assign out_nan_o = 1'b0;
`endif

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Randomized bench for fp_stream_accumulator against an exact-integer float reference model.
module tb_fp_stream_accumulator;

  localparam int unsigned CntW    = 2;
  localparam logic [31:0] InitSum = 32'h0000_0000;
  localparam int          CntMax  = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, in_sub, in_last, out_valid, out_ready;
  logic            out_over, out_under, out_nan;
  logic [31:0]     in_data, out_sum;
  logic [CntW-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pk_data[$];
  logic        pk_sub[$];

  always #5 clk = ~clk;

  fp_stream_accumulator #(
    .CNT_W    (CntW),
    .INIT_SUM (InitSum)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sub_i    (in_sub),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum),
    .out_count_o (out_count),
    .out_over_o  (out_over),
    .out_under_o (out_under),
    .out_nan_o   (out_nan)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Magnitude as an exact integer count of 2^-149; subnormals count as zero.
  function automatic logic [299:0] fp_mag(input logic [31:0] x);
    logic [299:0] m;
    if (x[30:23] == 8'd0) return '0;
    m = '0;
    m[23:0] = {1'b1, x[22:0]};
    return m << (x[30:23] - 8'd1);
  endfunction

  // Returns {over, under, result}: exact sum, then round-to-nearest-even to single.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
    logic [31:0]        bn;
    logic signed [300:0] va, vb, v;
    logic [299:0]       m, one, rem, half;
    logic [24:0]        mant;
    logic               up, sgn;
    int                 p, sh, e;
    bn = {b[31] ^ sub, b[30:0]};
    if (fp_is_nan(a) || fp_is_nan(bn) || (fp_is_inf(a) && fp_is_inf(bn) && a[31] != bn[31]))
      return {2'b00, 32'h7FC0_0000};
    if (fp_is_inf(a)) return {2'b00, a};
    if (fp_is_inf(bn)) return {2'b00, bn};
    va = $signed({1'b0, fp_mag(a)});
    vb = $signed({1'b0, fp_mag(bn)});
    if (a[31]) va = -va;
    if (bn[31]) vb = -vb;
    v = va + vb;
    if (v == 0) return 34'd0;
    sgn = (v < 0);
    m = sgn ? 300'(-v) : 300'(v);
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p < 23) return {2'b01, sgn, 31'd0};
    sh   = p - 23;
    mant = 25'(m >> sh);
    one  = '0;
    one[0] = 1'b1;
    rem  = m & ((one << sh) - one);
    half = (sh > 0) ? (one << (sh - 1)) : '0;
    up   = (sh > 0) && ((rem > half) || (rem == half && mant[0]));
    mant = mant + 25'(up);
    e    = p - 22;
    if (mant[24]) begin
      mant = mant >> 1;
      e++;
    end
    if (e >= 255) return {2'b10, sgn, 8'hFF, 23'd0};
    return {2'b00, sgn, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 31);
    if (k == 0) r[30:0] = '0;
    else if (k == 1) r[30:23] = 8'd0;
    else if (k == 2) r[30:0] = {8'hFF, 23'd0};
    else if (k == 3) begin
      r[30:23] = 8'hFF;
      r[22]    = 1'b1;
    end
    else if (k < 6) r[30:23] = 8'($urandom_range(250, 254));
    else if (k < 8) r[30:23] = 8'($urandom_range(1, 6));
    else r[30:23] = 8'($urandom_range(118, 136));
    return r;
  endfunction

  task automatic add_beat(input logic [31:0] d, input logic s);
    pk_data.push_back(d);
    pk_sub.push_back(s);
  endtask

  // Drives the queued packet, checks the held result for hold_cycles+1 cycles, then hands off.
  task automatic run_packet(input string tag, input int gap_max, input int hold_cycles);
    logic [31:0] exp_sum;
    logic [33:0] r;
    logic        exp_over, exp_under, exp_nan;
    int          exp_cnt;
    exp_sum = InitSum;
    exp_over = 1'b0;
    exp_under = 1'b0;
    exp_nan = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < pk_data.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_sub   = 1'($urandom);
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
      check_eq({tag, " idle_valid"}, 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = pk_data[i];
      in_sub   = pk_sub[i];
      in_last  = (i == pk_data.size() - 1);
      @(negedge clk);
      r = ref_add(exp_sum, pk_data[i], pk_sub[i]);
      exp_sum   = r[31:0];
      exp_over  = exp_over | r[33];
      exp_under = exp_under | r[32];
      exp_nan   = exp_nan | fp_is_nan(pk_data[i]);
      if (exp_cnt < CntMax) exp_cnt++;
    end
`ifndef FP_ACC_NAN_STICKY_EN
    exp_nan = 1'b0;
`endif
    out_ready = 1'b0;
    for (int k = 0; k <= hold_cycles; k++) begin
      check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, " hold_ready"}, 32'(in_ready), 32'd0);
      check_eq({tag, " sum"}, out_sum, exp_sum);
      check_eq({tag, " count"}, 32'(out_count), 32'(exp_cnt));
      check_eq({tag, " over"}, 32'(out_over), 32'(exp_over));
      check_eq({tag, " under"}, 32'(out_under), 32'(exp_under));
      check_eq({tag, " nan"}, 32'(out_nan), 32'(exp_nan));
      in_valid  = 1'($urandom);
      in_data   = rand_fp();
      in_sub    = 1'($urandom);
      in_last   = 1'($urandom);
      out_ready = (k == hold_cycles);
      @(negedge clk);
    end
    check_eq({tag, " post_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, " post_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    pk_data.delete();
    pk_sub.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, " sum"}, out_sum, InitSum);
    check_eq({tag, " count"}, 32'(out_count), 32'd0);
    check_eq({tag, " flags"}, {29'd0, out_over, out_under, out_nan}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_sub = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    add_beat(32'h3F80_0000, 1'b0);
    add_beat(32'h4000_0000, 1'b0);
    add_beat(32'h3F00_0000, 1'b0);
    run_packet("add", 0, 0);

    add_beat(32'h4040_0000, 1'b0);
    add_beat(32'h3F80_0000, 1'b1);
    run_packet("sub", 0, 0);

    add_beat(32'h7F7F_FFFF, 1'b0);
    add_beat(32'h7F7F_FFFF, 1'b0);
    run_packet("ovf", 0, 1);
    add_beat(32'h3F80_0000, 1'b0);
    run_packet("post_ovf", 0, 0);

    add_beat(32'h3F80_0000, 1'b0);
    add_beat(32'h4000_0000, 1'b1);
    run_packet("bp", 0, 5);

    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    in_sub   = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_rst");
    add_beat(32'h3F80_0000, 1'b0);
    run_packet("after_rst", 0, 0);

    repeat (5) add_beat(32'h3F80_0000, 1'b0);
    run_packet("sat", 1, 0);

    add_beat(32'h3F80_0000, 1'b0);
    add_beat(32'h7FC0_0000, 1'b0);
    run_packet("nan", 0, 0);

    add_beat(32'h0080_0000, 1'b0);
    add_beat(32'h0080_0001, 1'b1);
    run_packet("tiny", 0, 0);

    for (int n = 0; n < 60; n++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) add_beat(rand_fp(), 1'($urandom));
      run_packet("rand", 2, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
